// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Package  : dmem_arb_pkg
// Brief    : Shared types and constants for the two-port data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

  localparam int DEF_ADDR_W = 64;
  localparam int DEF_DATA_W = 64;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
// ============================================================================
// Module   : rr_arb2
// Brief    : Combinational two-way round-robin pick; the port not granted last
//            time wins a tie.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt_onehot,
  output logic       any
);

  always_comb begin
    gnt_onehot = 2'b00;
    if (req == 2'b11) begin
      gnt_onehot = (last_grant == P0) ? 2'b10 : 2'b01;
    end else begin
      gnt_onehot = req;
    end
  end

  assign any = |req;

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Shares a single-port 64-bit data memory between two requesters
//            with round-robin arbitration and fully registered memory controls.
//            Optional: define DMEM_ARB_ALIGN_CHECK_EN for misalignment errors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  output logic              m0_err,
  output logic              m1_err,
`endif

  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_WriteData,
  output logic              mem_MemWrite,
  output logic              mem_MemRead,
  input  logic [DATA_W-1:0] mem_ReadData
);

  state_t              r_state;
  logic                r_last_grant;
  logic                r_id;
  logic                r_we;
  logic                r_misaligned;

  logic [1:0]          w_req;
  logic [1:0]          w_gnt;
  logic                w_any;
  logic                w_idle;
  logic                w_win_id;
  logic                w_win_we;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [DATA_W-1:0]   w_win_wdata;
  logic                w_win_mis;
  logic [DATA_W-1:0]   w_resp;

  assign w_req = {m1_req, m0_req};

  rr_arb2 u_rr_arb2 (
    .req        (w_req),
    .last_grant (r_last_grant),
    .gnt_onehot (w_gnt),
    .any        (w_any)
  );

  // Grants are combinational, so they are also forced low while reset is held.
  assign w_idle = (r_state == IDLE) && !rst;
  assign m0_gnt = w_idle && w_gnt[0];
  assign m1_gnt = w_idle && w_gnt[1];

  assign w_win_id    = w_gnt[1] ? P1 : P0;
  assign w_win_we    = (w_win_id == P1) ? m1_we    : m0_we;
  assign w_win_addr  = (w_win_id == P1) ? m1_addr  : m0_addr;
  assign w_win_wdata = (w_win_id == P1) ? m1_wdata : m0_wdata;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign w_win_mis = |w_win_addr[2:0];
`else
  assign w_win_mis = 1'b0;
`endif

  // Writes and rejected accesses answer with zero data.
  assign w_resp = (r_we || r_misaligned) ? '0 : mem_ReadData;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_last_grant  <= P1;
      r_id          <= P0;
      r_we          <= 1'b0;
      r_misaligned  <= 1'b0;
      mem_address   <= '0;
      mem_WriteData <= '0;
      mem_MemWrite  <= 1'b0;
      mem_MemRead   <= 1'b0;
      m0_rvalid     <= 1'b0;
      m1_rvalid     <= 1'b0;
      m0_rdata      <= '0;
      m1_rdata      <= '0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      m0_err        <= 1'b0;
      m1_err        <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_id          <= w_win_id;
            r_last_grant  <= w_win_id;
            r_we          <= w_win_we;
            r_misaligned  <= w_win_mis;
            mem_address   <= w_win_addr;
            mem_WriteData <= w_win_wdata;
            mem_MemWrite  <= w_win_we && !w_win_mis;
            mem_MemRead   <= !w_win_we && !w_win_mis;
            r_state       <= ACCESS;
          end
        end
        ACCESS: begin
          mem_MemWrite <= 1'b0;
          mem_MemRead  <= 1'b0;
          if (r_id == P0) begin
            m0_rdata  <= w_resp;
            m0_rvalid <= 1'b1;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
            m0_err    <= r_misaligned;
`endif
          end else begin
            m1_rdata  <= w_resp;
            m1_rvalid <= 1'b1;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
            m1_err    <= r_misaligned;
`endif
          end
          r_state <= RESP;
        end
        RESP: begin
          m0_rvalid <= 1'b0;
          m1_rvalid <= 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
          m0_err    <= 1'b0;
          m1_err    <= 1'b0;
`endif
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Self-checking bench for dmem_arbiter: directed scenarios plus random
//            traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_arbiter;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          hold;   // -1: hold until granted, else give up after this many waits
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        preload;

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [63:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [63:0] m0_rdata, m1_rdata;
  logic [63:0] mem_address, mem_WriteData, mem_ReadData;
  logic        mem_MemWrite, mem_MemRead;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic        m0_err, m1_err;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;

  txn_t        q0[$];
  txn_t        q1[$];

  logic [63:0] dev_mem [16];
  logic [63:0] ref_mem [16];

  int          m_stage;
  logic        m_port, m_we, m_mis, m_prefer;
  logic [63:0] m_addr, m_wdata, m_resp;
  logic [63:0] m_exp_rd [2];
  logic [1:0]  m_eg;

  logic        g0, g1;
  int          age0, age1, lim0, lim1;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .m0_req        (m0_req),
    .m0_we         (m0_we),
    .m0_addr       (m0_addr),
    .m0_wdata      (m0_wdata),
    .m0_gnt        (m0_gnt),
    .m0_rvalid     (m0_rvalid),
    .m0_rdata      (m0_rdata),
    .m1_req        (m1_req),
    .m1_we         (m1_we),
    .m1_addr       (m1_addr),
    .m1_wdata      (m1_wdata),
    .m1_gnt        (m1_gnt),
    .m1_rvalid     (m1_rvalid),
    .m1_rdata      (m1_rdata),
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    .m0_err        (m0_err),
    .m1_err        (m1_err),
`endif
    .mem_address   (mem_address),
    .mem_WriteData (mem_WriteData),
    .mem_MemWrite  (mem_MemWrite),
    .mem_MemRead   (mem_MemRead),
    .mem_ReadData  (mem_ReadData)
  );

  function automatic logic [63:0] init_word(input int i);
    return 64'hC0DE_0000_0000_0000 | (64'(i) * 64'h0001_0203_0405_0607);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int p, input logic we, input logic [63:0] a,
                      input logic [63:0] wd, input int hold);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = wd; t.hold = hold;
    if (p == 0) q0.push_back(t);
    else        q1.push_back(t);
  endtask

  // Behavioural memory: combinational read, write on the clock while MemWrite is high.
  assign mem_ReadData = dev_mem[mem_address[6:3]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) dev_mem[i] <= init_word(i);
    end else if (mem_MemWrite) begin
      dev_mem[mem_address[6:3]] <= mem_WriteData;
    end
  end

  // Reference model: one access in flight, served as grant -> access -> response.
  initial begin : model
    m_stage = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_stage = 0; m_prefer = 1'b0; m_port = 1'b0; m_we = 1'b0; m_mis = 1'b0;
        m_addr = '0; m_wdata = '0; m_exp_rd[0] = '0; m_exp_rd[1] = '0;
        if (preload) for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        continue;
      end
      m_eg = 2'b00;
      if (m_stage == 0) begin
        if (m0_req && m1_req) m_eg = m_prefer ? 2'b10 : 2'b01;
        else                  m_eg = {m1_req, m0_req};
      end
      check_eq("m0_gnt", m0_gnt, m_eg[0]);
      check_eq("m1_gnt", m1_gnt, m_eg[1]);
      check_eq("mem_MemWrite", mem_MemWrite, (m_stage == 1) && m_we && !m_mis);
      check_eq("mem_MemRead", mem_MemRead, (m_stage == 1) && !m_we && !m_mis);
      check_eq("mem_address", mem_address, m_addr);
      check_eq("mem_WriteData", mem_WriteData, m_wdata);
      check_eq("m0_rvalid", m0_rvalid, (m_stage == 2) && (m_port == 1'b0));
      check_eq("m1_rvalid", m1_rvalid, (m_stage == 2) && (m_port == 1'b1));
      check_eq("m0_rdata", m0_rdata, m_exp_rd[0]);
      check_eq("m1_rdata", m1_rdata, m_exp_rd[1]);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      check_eq("m0_err", m0_err, (m_stage == 2) && (m_port == 1'b0) && m_mis);
      check_eq("m1_err", m1_err, (m_stage == 2) && (m_port == 1'b1) && m_mis);
`endif
      if (m_stage == 1) begin
        if (m_mis)     m_resp = '0;
        else if (m_we) begin m_resp = '0; ref_mem[m_addr[6:3]] = m_wdata; end
        else           m_resp = ref_mem[m_addr[6:3]];
        m_exp_rd[m_port] = m_resp;
        m_stage = 2;
      end else if (m_stage == 2) begin
        m_stage = 0;
      end else if (m_eg != 2'b00) begin
        m_port  = m_eg[1];
        m_we    = m_port ? m1_we    : m0_we;
        m_addr  = m_port ? m1_addr  : m0_addr;
        m_wdata = m_port ? m1_wdata : m0_wdata;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        m_mis   = (m_addr % 8) != 0;
`else
        m_mis   = 1'b0;
`endif
        m_prefer = !m_port;
        m_stage  = 1;
      end
    end
  end

  // Requester driver: holds each transaction until granted or its patience runs out.
  initial begin : driver
    txn_t t;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; age0 = 0; lim0 = -1;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; age1 = 0; lim1 = -1;
    forever begin
      @(negedge clk);
      g0 = m0_gnt; g1 = m1_gnt;
      @(posedge clk); #1;
      if (rst) begin
        m0_req = 0; m1_req = 0; q0.delete(); q1.delete();
        continue;
      end
      if (m0_req && g0) m0_req = 0;
      else if (m0_req) begin age0++; if (lim0 >= 0 && age0 > lim0) m0_req = 0; end
      if (!m0_req && q0.size() > 0) begin
        t = q0.pop_front();
        m0_req = 1; m0_we = t.we; m0_addr = t.addr; m0_wdata = t.wdata; lim0 = t.hold; age0 = 0;
      end
      if (m1_req && g1) m1_req = 0;
      else if (m1_req) begin age1++; if (lim1 >= 0 && age1 > lim1) m1_req = 0; end
      if (!m1_req && q1.size() > 0) begin
        t = q1.pop_front();
        m1_req = 1; m1_we = t.we; m1_addr = t.addr; m1_wdata = t.wdata; lim1 = t.hold; age1 = 0;
      end
    end
  end

  task automatic drain();
    bit done = 0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clk);
      #1;
      if (q0.size() == 0 && q1.size() == 0 && !m0_req && !m1_req && m_stage == 0) done = 1;
    end
    if (!done) check_eq("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_gnt"}, {m0_gnt, m1_gnt}, 64'd0);
    check_eq({tag, "_rvalid"}, {m0_rvalid, m1_rvalid}, 64'd0);
    check_eq({tag, "_rdata0"}, m0_rdata, 64'd0);
    check_eq({tag, "_rdata1"}, m1_rdata, 64'd0);
    check_eq({tag, "_strobes"}, {mem_MemWrite, mem_MemRead}, 64'd0);
    check_eq({tag, "_addr"}, mem_address, 64'd0);
    check_eq({tag, "_wdata"}, mem_WriteData, 64'd0);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    check_eq({tag, "_err"}, {m0_err, m1_err}, 64'd0);
`endif
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int p;
    logic [63:0] a;
    bit hit;
    rst = 1; preload = 1;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    preload = 0;
    @(posedge clk); #2 rst = 0;

    push(0, 1, 64'h10, 64'hDEADBEEF_CAFEF00D, -1);
    push(0, 0, 64'h10, 64'h0, -1);
    drain();

    for (int i = 0; i < 2; i++) begin
      push(0, 0, 64'h0, 64'h0, -1);
      push(1, 0, 64'h8, 64'h0, -1);
    end
    drain();

    push(1, 0, 64'h20, 64'h0, -1);
    push(1, 0, 64'h28, 64'h0, -1);
    push(1, 0, 64'h30, 64'h0, -1);
    drain();

    push(1, 1, 64'h18, 64'h1, -1);
    drain();
    push(0, 0, 64'h18, 64'h0, -1);
    drain();

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    push(0, 1, 64'h13, 64'h1234_5678_9ABC_DEF0, -1);
    push(0, 0, 64'h10, 64'h0, -1);
    drain();
`endif

    for (int i = 0; i < 300; i++) begin
      p = int'($urandom_range(0, 1));
      a = 64'($urandom_range(0, 15)) * 64'd8;
      if ($urandom_range(0, 9) == 0) a = a + 64'($urandom_range(1, 7));
      push(p, 1'($urandom_range(0, 1)), a, {$urandom, $urandom},
           ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1);
    end
    drain();

    // Reset in the middle of an access with both requesters still queued.
    push(0, 1, 64'h28, 64'h5555_AAAA_5555_AAAA, -1);
    push(1, 0, 64'h8, 64'h0, -1);
    push(0, 0, 64'h28, 64'h0, -1);
    push(1, 1, 64'h30, 64'h77, -1);
    hit = 0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge clk);
      if (m_stage == 1) hit = 1;
    end
    if (!hit) check_eq("access_wait_timeout", 64'd0, 64'd1);
    @(posedge clk); #3 rst = 1;
    #1 check_all_zero("midreset");
    @(posedge clk); #2 rst = 0;

    push(0, 0, 64'h8, 64'h0, -1);
    push(1, 0, 64'h30, 64'h0, -1);
    drain();
    push(0, 0, 64'h28, 64'h0, -1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
